// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the CPU M1 trace UART:
//   TRACE_SYNC         first byte of every frame
//   TRACE_FRAME_BYTES  bytes per frame (sync + pc + sp + 8 regs + checksum)
//   tx_state_e         per-byte UART transmitter states
//   seq_state_e        frame sequencer states (IDLE / SEND)
//   trace_byte()       selects frame byte N from the 96-bit snapshot
// Snapshot layout (96 bits): {pc[15:0], sp[15:0], b, c, d, e, h, l, a, f}.
// -----------------------------------------------------------------------------
package trace_pkg;

  localparam logic [7:0] TRACE_SYNC        = 8'hA5;
  localparam int         TRACE_FRAME_BYTES = 14;
  localparam logic [3:0] TRACE_LAST_IDX    = 4'(TRACE_FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_SEND = 1'b1
  } seq_state_e;

  // XOR of the 12 payload bytes (frame bytes 1..12).
  function automatic logic [7:0] trace_checksum(input logic [95:0] snap);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < 12; k++) begin
      c = c ^ snap[8*k +: 8];
    end
    return c;
  endfunction

  // Frame byte idx: 0 = sync, 1..12 = payload MSB first, 13 = checksum.
  function automatic logic [7:0] trace_byte(input logic [95:0] snap,
                                            input logic [3:0]  idx);
    logic [7:0] b;
    b = TRACE_SYNC;
    if (idx >= 4'd1 && idx <= 4'd12) begin
      b = snap[8*(12 - int'(idx)) +: 8];
    end else if (idx == TRACE_LAST_IDX) begin
      b = trace_checksum(snap);
    end
    return b;
  endfunction

endpackage

// File: rtl/cpu_trace_uart_if.sv
// -----------------------------------------------------------------------------
// cpu_trace_uart_if
// Bundles the trace-port signals between the CPU side and cpu_trace_uart.
//   enable, m1_start, pc, sp, regs   CPU side -> tracer
//   tx, busy, dropped                tracer -> CPU side / pin
//   tx_state, seq_state              tracer FSM states, for observation only
// Modports: master = CPU/host side, slave = tracer.
// -----------------------------------------------------------------------------
interface cpu_trace_uart_if;
  import trace_pkg::*;

  logic        enable;
  logic        m1_start;
  logic [15:0] pc;
  logic [15:0] sp;
  logic [63:0] regs;
  logic        tx;
  logic        busy;
  logic [15:0] dropped;
  tx_state_e   tx_state;
  seq_state_e  seq_state;

  modport master (
    output enable, m1_start, pc, sp, regs,
    input  tx, busy, dropped, tx_state, seq_state
  );

  modport slave (
    input  enable, m1_start, pc, sp, regs,
    output tx, busy, dropped, tx_state, seq_state
  );

endinterface

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 UART transmitter for one byte at a time, LSB first, line idles high.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load_i, data_i  byte offer from the sequencer
//   ready_o         transmitter can take a byte this cycle
//   tx_o            registered UART line
//   state_o         current FSM state
// Handshake: a byte is transferred on a rising clk edge where load_i and
// ready_o are both 1. ready_o is high in IDLE and during the final cycle of
// the STOP bit, so a byte offered then starts its START bit on the very next
// cycle with no idle gap between bytes. load_i is ignored while ready_o is 0.
// -----------------------------------------------------------------------------
module uart_tx_byte
  import trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output tx_state_e  state_o
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_RELOAD = TW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_done;

  // Down-counter hits zero in the last cycle of the current bit.
  assign bit_done = (timer_q == '0);
  assign ready_o  = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_done);
  assign tx_o     = tx_q;
  assign state_o  = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= TX_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = bit_done ? BIT_RELOAD : (timer_q - TW'(1));
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;

    unique case (state_q)
      TX_IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
      end
      TX_START: begin
        if (bit_done) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            // Shift so the next bit to send always sits in shreg_q[0].
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          state_d = TX_IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Accepting a byte overrides the STOP->IDLE step above.
    if (load_i && ready_o) begin
      state_d   = TX_START;
      timer_d   = BIT_RELOAD;
      bit_idx_d = '0;
      shreg_d   = data_i;
      tx_d      = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_trace_uart.sv
// -----------------------------------------------------------------------------
// cpu_trace_uart
// On each i8080 M1 pulse, snapshots PC, SP and B,C,D,E,H,L,A,F and sends them
// as one 14-byte UART frame: A5, pc hi/lo, sp hi/lo, b..f, XOR(bytes 1..12).
// Ports:
//   clk   sys_clk, rising edge
//   rst   synchronous active-low reset
//   bus   cpu_trace_uart_if.slave: enable, m1_start, pc, sp, regs in;
//         tx, busy, dropped (saturating lost-M1 count), FSM states out
// While a frame is in flight (busy) the snapshot is frozen; enabled M1
// pulses that arrive then are counted in dropped instead of being captured.
// -----------------------------------------------------------------------------
module cpu_trace_uart
  import trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic            clk,
  input  logic            rst,
  cpu_trace_uart_if.slave bus
);

  seq_state_e  seq_state_q, seq_state_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [95:0] snap_q, snap_d;
  logic [15:0] dropped_q, dropped_d;

  logic        capture;
  logic        drop;
  logic        last_byte;
  logic [3:0]  next_idx;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_line;
  tx_state_e   tx_state;

  assign capture   = bus.m1_start && bus.enable && (seq_state_q == SEQ_IDLE);
  assign drop      = bus.m1_start && bus.enable && (seq_state_q == SEQ_SEND);
  assign last_byte = (byte_idx_q == TRACE_LAST_IDX);
  assign next_idx  = byte_idx_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_state_q <= SEQ_IDLE;
      byte_idx_q  <= '0;
      snap_q      <= '0;
      dropped_q   <= '0;
    end else begin
      seq_state_q <= seq_state_d;
      byte_idx_q  <= byte_idx_d;
      snap_q      <= snap_d;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    seq_state_d = seq_state_q;
    byte_idx_d  = byte_idx_q;
    snap_d      = snap_q;
    tx_load     = 1'b0;
    tx_data     = TRACE_SYNC;

    unique case (seq_state_q)
      SEQ_IDLE: begin
        // The sync byte is constant, so it is handed to the transmitter in
        // the capture cycle itself; the start bit begins the next cycle.
        if (capture) begin
          snap_d      = {bus.pc, bus.sp, bus.regs};
          byte_idx_d  = '0;
          seq_state_d = SEQ_SEND;
          tx_load     = 1'b1;
          tx_data     = TRACE_SYNC;
        end
      end
      SEQ_SEND: begin
        // While sending, tx_ready only rises in the last STOP cycle.
        if (tx_ready) begin
          if (last_byte) begin
            seq_state_d = SEQ_IDLE;
            byte_idx_d  = '0;
          end else begin
            byte_idx_d = next_idx;
            tx_load    = 1'b1;
            tx_data    = trace_byte(snap_q, next_idx);
          end
        end
      end
      default: begin
        seq_state_d = SEQ_IDLE;
        byte_idx_d  = '0;
      end
    endcase
  end

  always_comb begin
    dropped_d = dropped_q;
    if (drop && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tx_load),
    .data_i  (tx_data),
    .ready_o (tx_ready),
    .tx_o    (tx_line),
    .state_o (tx_state)
  );

  assign bus.tx        = tx_line;
  assign bus.busy      = (seq_state_q == SEQ_SEND);
  assign bus.dropped   = dropped_q;
  assign bus.tx_state  = tx_state;
  assign bus.seq_state = seq_state_q;

endmodule

// File: tb/tb_cpu_trace_uart.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_uart
// Directed bench for cpu_trace_uart with CLKS_PER_BIT = 4. Expected frame
// bytes are pushed when an M1 pulse should be captured; a UART decoder pops
// and compares each received byte.
// -----------------------------------------------------------------------------
module tb_cpu_trace_uart;
  import trace_pkg::*;

  localparam int CPB        = 4;
  localparam int FRAME_CLKS = 14 * 10 * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_trace_uart_if ifc();

  cpu_trace_uart #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame built from the frame format: sync, pc, sp, b..f, XOR.
  task automatic push_frame(input logic [15:0] pc, input logic [15:0] sp,
                            input logic [63:0] regs);
    logic [7:0] b [14];
    logic [7:0] cs;
    b[0] = 8'hA5;
    b[1] = pc[15:8];
    b[2] = pc[7:0];
    b[3] = sp[15:8];
    b[4] = sp[7:0];
    for (int k = 0; k < 8; k++) b[5+k] = regs[63-8*k -: 8];
    cs = 8'h00;
    for (int k = 1; k <= 12; k++) cs = cs ^ b[k];
    b[13] = cs;
    for (int k = 0; k < 14; k++) exp_q.push_back(b[k]);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; m1_start is high across exactly one rising edge.
  task automatic pulse_m1(input logic [15:0] pc, input logic [15:0] sp,
                          input logic [63:0] regs);
    ifc.pc       = pc;
    ifc.sp       = sp;
    ifc.regs     = regs;
    ifc.m1_start = 1'b1;
    @(negedge clk);
    ifc.m1_start = 1'b0;
    ifc.pc       = 16'($urandom);
    ifc.sp       = 16'($urandom);
    ifc.regs     = {$urandom, $urandom};
  endtask

  task automatic send_frame(input logic [15:0] pc, input logic [15:0] sp,
                            input logic [63:0] regs);
    push_frame(pc, sp, regs);
    pulse_m1(pc, sp, regs);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (ifc.busy === 1'b1 && n < 4 * FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(ifc.busy), 64'(0));
    repeat (2 * CPB) @(negedge clk);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- UART decoder ----------------
  initial begin : uart_monitor
    logic [7:0] rx;
    logic       stop_bit;
    logic [7:0] exp;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && ifc.tx === 1'b0) begin
        aborted = 1'b0;
        repeat (CPB / 2) begin
          @(negedge clk);
          if (rst !== 1'b1) aborted = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin
            @(negedge clk);
            if (rst !== 1'b1) aborted = 1'b1;
          end
          rx[i] = ifc.tx;
        end
        repeat (CPB) begin
          @(negedge clk);
          if (rst !== 1'b1) aborted = 1'b1;
        end
        stop_bit = ifc.tx;
        if (!aborted) begin
          check("rx_stop_bit", 64'(stop_bit), 64'(1));
          check("rx_byte_expected", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("rx_byte", 64'(rx), 64'(exp));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int cnt;
    int low_cnt;
    int busy_cnt;

    rst          = 1'b0;
    ifc.enable   = 1'b1;
    ifc.m1_start = 1'b0;
    ifc.pc       = '0;
    ifc.sp       = '0;
    ifc.regs     = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 64'(ifc.tx), 64'(1));
    check("reset_busy", 64'(ifc.busy), 64'(0));
    check("reset_dropped", 64'(ifc.dropped), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: latency, content, busy duration.
    send_frame(16'h0123, 16'h2400, 64'h00_01_02_03_04_05_06_07);
    check("latency_tx_low", 64'(ifc.tx), 64'(0));
    check("latency_busy", 64'(ifc.busy), 64'(1));
    cnt = 0;
    while (ifc.busy === 1'b1 && cnt < 4 * FRAME_CLKS) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(cnt), 64'(FRAME_CLKS));
    repeat (2 * CPB) @(negedge clk);
    check("frame1_drained", 64'(exp_q.size()), 64'(0));

    // Drops during a frame; frame carries the first snapshot.
    send_frame(16'hBEEF, 16'hFFF0, 64'h11_22_33_44_55_66_77_88);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(5, 60)) @(negedge clk);
      pulse_m1(16'($urandom), 16'($urandom), {$urandom, $urandom});
    end
    check("drop_count", 64'(ifc.dropped), 64'(5));
    wait_idle("drop_frame_idle");

    // Boundary: M1 on the final STOP cycle drops, one cycle later captures.
    send_frame(16'h8000, 16'h0001, 64'hFF_EE_DD_CC_BB_AA_99_88);
    repeat (FRAME_CLKS - 1) @(negedge clk);
    check("boundary_busy_last_stop", 64'(ifc.busy), 64'(1));
    pulse_m1(16'hDEAD, 16'hDEAD, 64'hDEAD_DEAD_DEAD_DEAD);
    check("boundary_idle_gap_busy", 64'(ifc.busy), 64'(0));
    check("boundary_idle_gap_tx", 64'(ifc.tx), 64'(1));
    check("boundary_drop", 64'(ifc.dropped), 64'(6));
    send_frame(16'h1234, 16'h5678, 64'h0A_0B_0C_0D_0E_0F_10_11);
    check("boundary_restart_busy", 64'(ifc.busy), 64'(1));
    check("boundary_restart_tx", 64'(ifc.tx), 64'(0));
    wait_idle("boundary_idle");

    // Reset mid-frame.
    send_frame(16'h4242, 16'h1111, 64'h01_23_45_67_89_AB_CD_EF);
    repeat (100) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_first", 64'(ifc.tx), 64'(1));
    repeat (2) @(negedge clk);
    exp_q.delete();
    check("midrst_tx", 64'(ifc.tx), 64'(1));
    check("midrst_busy", 64'(ifc.busy), 64'(0));
    check("midrst_dropped", 64'(ifc.dropped), 64'(0));
    rst = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ifc.tx !== 1'b1) low_cnt++;
    end
    check("midrst_quiet_tx", 64'(low_cnt), 64'(0));
    check("midrst_quiet_busy", 64'(ifc.busy), 64'(0));

    // Enable low: pulses are ignored entirely.
    ifc.enable = 1'b0;
    low_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      pulse_m1(16'($urandom), 16'($urandom), {$urandom, $urandom});
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        if (ifc.tx !== 1'b1) low_cnt++;
        if (ifc.busy !== 1'b0) busy_cnt++;
      end
    end
    check("enable_tx_idle", 64'(low_cnt), 64'(0));
    check("enable_busy", 64'(busy_cnt), 64'(0));
    check("enable_dropped", 64'(ifc.dropped), 64'(0));
    ifc.enable = 1'b1;

    // Saturation of the drop counter.
    send_frame(16'hCAFE, 16'hF00D, 64'h55_AA_55_AA_00_FF_00_FF);
    force dut.dropped_q = 16'hFFFE;
    @(negedge clk);
    release dut.dropped_q;
    @(negedge clk);
    check("sat_preload", 64'(ifc.dropped), 64'(16'hFFFE));
    pulse_m1(16'h0001, 16'h0002, 64'h3);
    check("sat_first", 64'(ifc.dropped), 64'(16'hFFFF));
    pulse_m1(16'h0004, 16'h0005, 64'h6);
    pulse_m1(16'h0007, 16'h0008, 64'h9);
    check("sat_hold", 64'(ifc.dropped), 64'(16'hFFFF));
    wait_idle("sat_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
